// File: rtl/ins_mem_pkg.sv
// Shared definitions for the writable instruction memory.
// The controller and the top level take their state encoding and default
// widths from here, so the decoder and the fetch stage agree on sizes.
package ins_mem_pkg;

  localparam int unsigned INS_IW_DEF    = 9;
  localparam int unsigned INS_AW_DEF    = 4;
  localparam int unsigned INS_DEPTH_DEF = 16;

  localparam logic [INS_IW_DEF-1:0] INS_NOP_DEF = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } ins_mem_state_e;

endpackage

// File: rtl/ins_mem_prog_ctrl.sv
// Load/run controller for the instruction memory.
// Owns the IDLE/LOAD/RUN state machine, the sequential write pointer and
// the completion pulse.
//   clk, rst          clock, async active-high reset
//   prog_start        enter LOAD / restart the write pointer
//   prog_we/last      write strobe and final-word qualifier
//   fetch_req         fetch request from the CPU
//   wr_en_c, wr_addr  memory write strobe (comb) and address
//   fetch_en_c        fetch accepted this cycle (comb)
//   prog_done         one-cycle pulse after the final write
//   busy, ready       registered LOAD / RUN indicators
module ins_mem_prog_ctrl
  import ins_mem_pkg::*;
#(
  parameter int unsigned AW    = INS_AW_DEF,
  parameter int unsigned DEPTH = INS_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_start,
  input  logic          prog_we,
  input  logic          prog_last,
  input  logic          fetch_req,
  output logic          wr_en_c,
  output logic [AW-1:0] wr_addr,
  output logic          fetch_en_c,
  output logic          prog_done,
  output logic          busy,
  output logic          ready
);

  // One spare bit so the pointer can never alias back onto word 0.
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  ins_mem_state_e state, state_nxt;
  logic [PW-1:0]  wptr, wptr_nxt;
  logic           done_nxt;

  // State, pointer and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wptr      <= '0;
      prog_done <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      wptr      <= wptr_nxt;
      prog_done <= done_nxt;
      busy      <= (state_nxt == ST_LOAD);
      ready     <= (state_nxt == ST_RUN);
    end
  end

  // Next-state logic; PROG_START outranks both writes and fetches.
  always_comb begin
    state_nxt  = state;
    wptr_nxt   = wptr;
    done_nxt   = 1'b0;
    wr_en_c    = 1'b0;
    fetch_en_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (prog_start) begin
          state_nxt = ST_LOAD;
          wptr_nxt  = '0;
        end
      end
      ST_LOAD: begin
        if (prog_start) begin
          wptr_nxt = '0;
        end else if (prog_we) begin
          wr_en_c = 1'b1;
          if (prog_last || (wptr == LAST_PTR)) begin
            state_nxt = ST_RUN;
            wptr_nxt  = '0;
            done_nxt  = 1'b1;
          end else begin
            wptr_nxt = wptr + PW'(1);
          end
        end
      end
      ST_RUN: begin
        if (prog_start) begin
          state_nxt = ST_LOAD;
          wptr_nxt  = '0;
        end else begin
          fetch_en_c = fetch_req;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        wptr_nxt  = '0;
      end
    endcase
  end

  assign wr_addr = AW'(wptr);

endmodule

// File: rtl/ins_mem_prog.sv
// Writable instruction memory: DEPTH words of IW bits held in registers,
// loaded sequentially through the programming port and read by the fetch
// stage with a registered, single-cycle-latency request/valid port.
//   CLK, RST                         clock, async active-high reset
//   PROG_START/WE/LAST, PROG_DATA    programming port
//   PROG_DONE, BUSY, READY           load status
//   FETCH_REQ, PC                    fetch request and address
//   INS, INS_VALID, INS_ERR          registered fetch response
module ins_mem_prog
  import ins_mem_pkg::*;
#(
  parameter int unsigned     IW      = INS_IW_DEF,
  parameter int unsigned     AW      = INS_AW_DEF,
  parameter int unsigned     DEPTH   = INS_DEPTH_DEF,
  parameter logic [IW-1:0]   NOP_INS = IW'(INS_NOP_DEF)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PROG_START,
  input  logic          PROG_WE,
  input  logic          PROG_LAST,
  input  logic [IW-1:0] PROG_DATA,
  output logic          PROG_DONE,
  output logic          BUSY,
  output logic          READY,
  input  logic          FETCH_REQ,
  input  logic [AW-1:0] PC,
  output logic [IW-1:0] INS,
  output logic          INS_VALID,
  output logic          INS_ERR
);

  localparam int unsigned PW = AW + 1;

  if (DEPTH < 1 || DEPTH > (2 ** AW)) begin : g_depth_chk
    $error("ins_mem_prog: DEPTH out of range for AW");
  end

  logic [IW-1:0] mem [DEPTH];
  logic          wr_en_c;
  logic [AW-1:0] wr_addr;
  logic          fetch_en_c;
  logic          in_range_c;

  ins_mem_prog_ctrl #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk        (CLK),
    .rst        (RST),
    .prog_start (PROG_START),
    .prog_we    (PROG_WE),
    .prog_last  (PROG_LAST),
    .fetch_req  (FETCH_REQ),
    .wr_en_c    (wr_en_c),
    .wr_addr    (wr_addr),
    .fetch_en_c (fetch_en_c),
    .prog_done  (PROG_DONE),
    .busy       (BUSY),
    .ready      (READY)
  );

  // Compare one bit wider so DEPTH == 2**AW is representable.
  assign in_range_c = ({1'b0, PC} < PW'(DEPTH));

  // Storage array; load and fetch never overlap because they are state-exclusive.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem <= '{default: NOP_INS};
    end else if (wr_en_c) begin
      mem[wr_addr] <= PROG_DATA;
    end
  end

  // Registered fetch response; INS holds when no request is accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      INS       <= NOP_INS;
      INS_VALID <= 1'b0;
      INS_ERR   <= 1'b0;
    end else begin
      INS_VALID <= fetch_en_c;
      INS_ERR   <= fetch_en_c && !in_range_c;
      if (fetch_en_c) begin
        INS <= in_range_c ? mem[PC] : NOP_INS;
      end
    end
  end

endmodule

// File: tb/tb_ins_mem_prog.sv
// Bench for ins_mem_prog: a 16-word instance checked through a fetch
// scoreboard, plus a 12-word instance for out-of-range addressing.
module tb_ins_mem_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps, we, last, freq;
  logic [8:0] data;
  logic [3:0] pc;
  logic       done, busy, ready, iv, ie;
  logic [8:0] ins;

  logic       ps12, we12, last12, freq12;
  logic [8:0] data12;
  logic [3:0] pc12;
  logic       done12, busy12, ready12, iv12, ie12;
  logic [8:0] ins12;

  typedef struct {
    logic [8:0] ins;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] exp_mem [16];
  logic [8:0] wr_buf  [16];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         done_snap;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ins_mem_prog dut (
    .CLK(clk), .RST(rst), .PROG_START(ps), .PROG_WE(we), .PROG_LAST(last),
    .PROG_DATA(data), .PROG_DONE(done), .BUSY(busy), .READY(ready),
    .FETCH_REQ(freq), .PC(pc), .INS(ins), .INS_VALID(iv), .INS_ERR(ie)
  );

  ins_mem_prog #(.DEPTH(12)) dut12 (
    .CLK(clk), .RST(rst), .PROG_START(ps12), .PROG_WE(we12), .PROG_LAST(last12),
    .PROG_DATA(data12), .PROG_DONE(done12), .BUSY(busy12), .READY(ready12),
    .FETCH_REQ(freq12), .PC(pc12), .INS(ins12), .INS_VALID(iv12), .INS_ERR(ie12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every INS_VALID must match the oldest expectation
  // in the exact cycle it was due.
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (iv) begin
      if (sb.size() == 0) begin
        chk("unexp_valid", 32'(iv), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("fetch_lat", 32'(cyc), 32'(e.cyc));
        chk("fetch_ins", 32'(ins), 32'(e.ins));
        chk("fetch_err", 32'(ie), 32'(e.err));
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk("missing_valid", 32'(iv), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // PROG_START pulse, then n writes from wr_buf; PROG_LAST on word last_at.
  task automatic do_load(input int n, input int last_at);
    step();
    ps = 1'b1;
    step();
    ps = 1'b0;
    for (int k = 0; k < n; k++) begin
      we   = 1'b1;
      data = wr_buf[k];
      last = (k == last_at);
      exp_mem[k] = wr_buf[k];
      step();
    end
    we   = 1'b0;
    last = 1'b0;
  endtask

  task automatic fetch(input int a);
    exp_t e;
    freq  = 1'b1;
    pc    = 4'(a);
    e.ins = exp_mem[a];
    e.err = 1'b0;
    e.cyc = cyc + 1;
    sb.push_back(e);
    step();
    freq = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ps = 0; we = 0; last = 0; freq = 0; data = '0; pc = '0;
    ps12 = 0; we12 = 0; last12 = 0; freq12 = 0; data12 = '0; pc12 = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_ins",   32'(ins),   32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_err",   32'(ie),    32'd0);

    // Fetch in IDLE is ignored.
    freq = 1'b1; pc = 4'd3;
    step();
    freq = 1'b0;
    chk("idle_fetch_valid", 32'(iv), 32'd0);
    chk("idle_fetch_ins",   32'(ins), 32'd0);

    // Full 16-word load; completion forced by the last address.
    for (int i = 0; i < 16; i++)
      wr_buf[i] = (i < 9) ? 9'(1 << i) : 9'(9'h1FE - 21 * (i - 9));
    do_load(16, -1);
    chk("full_done",  32'(done),  32'd1);
    chk("full_ready", 32'(ready), 32'd1);
    chk("full_busy",  32'(busy),  32'd0);
    step();
    chk("full_done_pulse", 32'(done), 32'd0);
    chk("full_done_cnt", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 16; i++) fetch(i);
    step();
    step();

    // Early termination with PROG_LAST.
    wr_buf[0] = 9'h0AA;
    wr_buf[1] = 9'h155;
    do_load(2, 1);
    chk("early_done",  32'(done),  32'd1);
    chk("early_ready", 32'(ready), 32'd1);
    fetch(1);
    fetch(5);
    step();
    chk("early_ins_hold", 32'(ins), 32'(exp_mem[5]));

    // PROG_START wins over a same-cycle fetch in RUN.
    ps = 1'b1; freq = 1'b1; pc = 4'd2;
    step();
    ps = 1'b0; freq = 1'b0;
    chk("coll_run_busy",  32'(busy), 32'd1);
    chk("coll_run_valid", 32'(iv),   32'd0);
    chk("coll_run_ins",   32'(ins),  32'(exp_mem[5]));
    // In LOAD: a write, then PROG_START with a dropped write, then the final word.
    we = 1'b1; data = 9'h0C3;
    step();
    ps = 1'b1; data = 9'h111;
    step();
    ps = 1'b0; data = 9'h0F0; last = 1'b1;
    step();
    we = 1'b0; last = 1'b0;
    exp_mem[0] = 9'h0F0;
    chk("coll_load_done", 32'(done), 32'd1);
    fetch(0);
    fetch(1);
    fetch(2);
    step();
    step();
    chk("ins_pre_rst", 32'(ins), 32'(exp_mem[2]));

    // Reset in the middle of a load.
    step();
    ps = 1'b1;
    step();
    ps = 1'b0;
    for (int k = 0; k < 5; k++) begin
      we = 1'b1; data = 9'(9'h1A0 + k);
      step();
    end
    we = 1'b0;
    done_snap = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ins",  32'(ins),  32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    step();
    step();
    chk("rst_load_no_done", 32'(done_cnt), 32'(done_snap));
    chk("rst_load_idle_busy", 32'(busy), 32'd0);
    wr_buf[0] = 9'h000;
    do_load(1, 0);
    chk("reload_done", 32'(done), 32'd1);
    for (int i = 0; i < 16; i++) fetch(i);
    step();
    step();

    // 12-word instance: forced completion and out-of-range fetches.
    step();
    ps12 = 1'b1;
    step();
    ps12 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      we12 = 1'b1; data12 = 9'(9'h100 + k);
      step();
    end
    we12 = 1'b0;
    chk("d12_done",  32'(done12),  32'd1);
    chk("d12_ready", 32'(ready12), 32'd1);
    freq12 = 1'b1; pc12 = 4'd11;
    step();
    freq12 = 1'b0;
    chk("d12_pc11_valid", 32'(iv12),  32'd1);
    chk("d12_pc11_err",   32'(ie12),  32'd0);
    chk("d12_pc11_ins",   32'(ins12), 32'h10B);
    freq12 = 1'b1; pc12 = 4'd13;
    step();
    freq12 = 1'b0;
    chk("d12_pc13_valid", 32'(iv12),  32'd1);
    chk("d12_pc13_err",   32'(ie12),  32'd1);
    chk("d12_pc13_ins",   32'(ins12), 32'd0);
    freq12 = 1'b1; pc12 = 4'd12;
    step();
    freq12 = 1'b0;
    chk("d12_pc12_err", 32'(ie12), 32'd1);
    step();
    chk("d12_idle_valid", 32'(iv12), 32'd0);
    chk("d12_idle_err",   32'(ie12), 32'd0);

    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ins_mem_prog.md
Name: ins_mem_prog

Overview:
- Parametrised, writable instruction memory that supersedes the fixed 16x9 instruction table.
- Holds DEPTH words of IW bits in registers. Each word resets to NOP_INS.
- Words are loaded sequentially through a programming port. An auto-incrementing write pointer supplies the addresses.
- The CPU fetch stage reads through a request/valid port with registered output and a 1-cycle latency.

Parameters:
- IW, 9, instruction word width in bits.
- AW, 4, PC / address width in bits.
- DEPTH, 16, number of implemented words; must satisfy 1 <= DEPTH <= 2^AW.
- NOP_INS, 0 (IW bits), word returned for invalid fetches; also the reset content of every word.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- PROG_START  in  1  pulse: enter LOAD and clear the write pointer to 0.
- PROG_WE  in  1  write strobe; in LOAD, writes PROG_DATA at the write pointer.
- PROG_LAST  in  1  qualifies PROG_WE: this word is the final word of the program.
- PROG_DATA  in  IW  instruction word to store.
- PROG_DONE  out  1  one-cycle pulse when loading completes.
- BUSY  out  1  high while in LOAD.
- READY  out  1  high while in RUN.
- FETCH_REQ  in  1  fetch request, sampled in RUN only.
- PC  in  AW  fetch address.
- INS  out  IW  fetched instruction (registered).
- INS_VALID  out  1  INS is valid this cycle; one-cycle pulse per accepted request.
- INS_ERR  out  1  accompanies INS_VALID when PC >= DEPTH.

Behaviour:
- Reset (async, RST=1):
  - State = IDLE; write pointer = 0.
  - All memory words = NOP_INS.
  - INS = NOP_INS; INS_VALID = INS_ERR = PROG_DONE = 0; BUSY = READY = 0.
  - Reset asserted mid-load or mid-fetch aborts everything; no partial state survives.
- State machine (encoding in shared package): IDLE, LOAD, RUN.
  - IDLE: PROG_START -> LOAD. PROG_WE and FETCH_REQ are ignored.
  - LOAD: BUSY=1.
    - Each PROG_WE writes mem[wptr] <= PROG_DATA, then wptr increments.
    - If PROG_LAST=1, or wptr == DEPTH-1 at the write, the cycle after the write has PROG_DONE=1, state = RUN and wptr = 0.
    - PROG_LAST without PROG_WE is ignored.
    - Words not written keep their previous contents.
  - RUN: READY=1.
    - A request (FETCH_REQ=1) with PC < DEPTH gives INS = mem[PC], INS_VALID=1, INS_ERR=0 in the next cycle.
    - A request with PC >= DEPTH gives INS = NOP_INS, INS_VALID=1, INS_ERR=1.
    - Back-to-back requests are supported at one per cycle; latency stays at exactly 1 cycle.
    - PROG_WE is ignored in RUN.
- PROG_START priority:
  - In RUN: -> LOAD. A FETCH_REQ in the same cycle is dropped; INS_VALID=0 next cycle and INS holds its value.
  - In LOAD: restarts wptr at 0. A PROG_WE in the same cycle is dropped.
- Output holding:
  - INS holds its last value when no fetch is accepted.
  - INS_VALID and INS_ERR are 0 in any cycle not following an accepted request.
- The write pointer is a full AW+1-bit-safe counter and never wraps past DEPTH-1; reaching the end forces completion.
- Read-during-write cannot happen, because fetch and load are mutually exclusive by state.

Decomposition:
- Shared package ins_mem_pkg:
  - State enum constants ST_IDLE, ST_LOAD, ST_RUN.
  - Default IW / AW / DEPTH and the default NOP_INS constant, so the decoder and the fetch stage share widths.
- One natural sub-module: ins_mem_prog_ctrl, containing the FSM, write pointer and PROG_DONE generation.
- Storage array and registered read stay in the top level.

Test Plan:
- Reset then fetch:
  - After RST, READY=0.
  - FETCH_REQ=1 with PC=3 -> INS_VALID stays 0 and INS = 0.
  - Async RST asserted mid-cycle clears INS immediately.
- Full load:
  - PROG_START, then 16 PROG_WE writes of 9'h001, 9'h002, 9'h004 ... (pattern i -> (1<<i) mod 512, others 9'h1FE down to 9'h180).
  - PROG_DONE pulses exactly once, the cycle after the 16th write; READY=1.
  - Fetch PC=0..15 back-to-back -> each word appears 1 cycle later with INS_VALID=1.
- Early termination:
  - PROG_START, write 9'h0AA, then 9'h155 with PROG_LAST=1 -> PROG_DONE, RUN.
  - PC=1 -> 9'h155. PC=5 -> the previous content, untouched.
- Out-of-range (DEPTH=12, AW=4):
  - Fetch PC=13 -> INS=NOP_INS, INS_VALID=1, INS_ERR=1.
  - Fetch PC=11 -> INS_ERR=0.
- Collisions:
  - PROG_START together with FETCH_REQ in RUN -> no INS_VALID; BUSY=1 next cycle.
  - PROG_START together with PROG_WE in LOAD -> no write; wptr=0.
- Reset mid-load: RST after 5 writes -> IDLE, all words NOP_INS, PROG_DONE never pulses.
